// File: rtl/gpgpu_icache_pkg.sv
// Shared instruction-cache constants and types for the GPGPU fetch path.
package gpgpu_icache_pkg;

  localparam int ICACHE_ADDR_W = 10;
  localparam int ICACHE_DATA_W = 32;
  localparam int NUM_WARPS     = 8;
  localparam int ICACHE_RD_LAT = 2;
  localparam int WARP_ID_W     = $clog2(NUM_WARPS);

  typedef logic [WARP_ID_W-1:0] warp_id_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, wrapping modulo N (N a power of two).
module rr_arbiter #(
  parameter int  N  = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // scan from ptr; the first hit locks out all later candidates
  always_comb begin
    logic [IW-1:0] cand;
    logic          hit;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    hit  = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand      = ptr + IW'(i);
      hit       = !any && req[cand];
      gnt[cand] = gnt[cand] | hit;
      idx       = hit ? cand : idx;
      any       = any | hit;
    end
  end

endmodule

// File: rtl/icache_port_arbiter.sv
// Arbitrates ICache BRAM port A between host-loader writes and round-robin warp fetches,
// tagging each read response with its warp id after the fixed BRAM read latency.
module icache_port_arbiter #(
  parameter int  NUM_WARPS = gpgpu_icache_pkg::NUM_WARPS,
  parameter int  ADDR_W    = gpgpu_icache_pkg::ICACHE_ADDR_W,
  parameter int  DATA_W    = gpgpu_icache_pkg::ICACHE_DATA_W,
  parameter int  RD_LAT    = gpgpu_icache_pkg::ICACHE_RD_LAT,
  localparam int WID_W     = $clog2(NUM_WARPS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        host_wr_en,
  input  logic [ADDR_W-1:0]           host_wr_addr,
  input  logic [DATA_W-1:0]           host_wr_data,
  input  logic                        flush,
  input  logic [NUM_WARPS-1:0]        fetch_req,
  input  logic [NUM_WARPS*ADDR_W-1:0] fetch_addr,
  output logic [NUM_WARPS-1:0]        fetch_gnt,
  output logic                        resp_valid,
  output logic [WID_W-1:0]            resp_warp,
  output logic [DATA_W-1:0]           resp_data,
  output logic                        bram_wena,
  output logic [ADDR_W-1:0]           bram_addra,
  output logic [DATA_W-1:0]           bram_dina,
  input  logic [DATA_W-1:0]           bram_douta
);

  logic [NUM_WARPS-1:0] pending_r;
  logic [WID_W-1:0]     ptr_r;
  logic [RD_LAT-1:0]    tag_valid_r;
  logic [WID_W-1:0]     tag_warp_r [RD_LAT];

  logic [NUM_WARPS-1:0] resp_clr_s;
  logic [NUM_WARPS-1:0] eligible_s;
  logic [NUM_WARPS-1:0] arb_gnt_s;
  logic [WID_W-1:0]     arb_idx_s;
  logic                 arb_any_s;
  logic                 grant_s;
  logic                 resp_fire_s;
  logic [ADDR_W-1:0]    warp_addr_s [NUM_WARPS];

  // a flush kills the response surfacing this very cycle as well as those still in flight
  assign resp_fire_s = tag_valid_r[RD_LAT-1] & ~flush;
  assign resp_clr_s  = NUM_WARPS'(resp_fire_s) << tag_warp_r[RD_LAT-1];
  // a warp whose response appears now may be re-granted in the same cycle
  assign eligible_s  = fetch_req & ~(pending_r & ~resp_clr_s);

  assign resp_valid  = resp_fire_s;
  assign resp_warp   = tag_warp_r[RD_LAT-1];
  assign resp_data   = bram_douta;

  // unpack per-warp program counters
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      warp_addr_s[w] = fetch_addr[w*ADDR_W +: ADDR_W];
    end
  end

  rr_arbiter #(.N(NUM_WARPS)) u_rr_arbiter (
    .req (eligible_s),
    .ptr (ptr_r),
    .gnt (arb_gnt_s),
    .idx (arb_idx_s),
    .any (arb_any_s)
  );

  // port-A priority mux: host write, else round-robin fetch, else idle
  always_comb begin
    fetch_gnt  = '0;
    bram_wena  = 1'b0;
    bram_addra = '0;
    bram_dina  = '0;
    grant_s    = 1'b0;
    if (!rst_n) begin
      grant_s = 1'b0;
    end else if (host_wr_en) begin
      bram_wena  = 1'b1;
      bram_addra = host_wr_addr;
      bram_dina  = host_wr_data;
    end else if (arb_any_s) begin
      fetch_gnt  = arb_gnt_s;
      bram_addra = warp_addr_s[arb_idx_s];
      grant_s    = 1'b1;
    end else begin
      bram_addra = '0;
    end
  end

  // round-robin pointer moves just past each granted warp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (grant_s) begin
      ptr_r <= arb_idx_s + WID_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // one outstanding fetch per warp, released by its response or by a flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= '0;
    end else if (flush) begin
      pending_r <= '0;
    end else begin
      pending_r <= (pending_r & ~resp_clr_s) | (grant_s ? arb_gnt_s : '0);
    end
  end

  // tag pipe tracks the BRAM's address-then-data register stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid_r <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_warp_r[i] <= '0;
      end
    end else begin
      tag_valid_r[0] <= grant_s & ~flush;
      tag_warp_r[0]  <= grant_s ? arb_idx_s : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_valid_r[i] <= tag_valid_r[i-1] & ~flush;
        tag_warp_r[i]  <= tag_warp_r[i-1];
      end
    end
  end

endmodule

// File: tb/tb_icache_port_arbiter.sv
// Scoreboard bench for icache_port_arbiter: directed scenarios plus randomized traffic,
// checked against a behavioural reference of the arbitration and response rules.
module tb_icache_port_arbiter;

  localparam int NW = gpgpu_icache_pkg::NUM_WARPS;
  localparam int AW = gpgpu_icache_pkg::ICACHE_ADDR_W;
  localparam int DW = gpgpu_icache_pkg::ICACHE_DATA_W;
  localparam int WW = gpgpu_icache_pkg::WARP_ID_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             host_wr_en;
  logic [AW-1:0]    host_wr_addr;
  logic [DW-1:0]    host_wr_data;
  logic             flush;
  logic [NW-1:0]    fetch_req;
  logic [NW*AW-1:0] fetch_addr;
  logic [NW-1:0]    fetch_gnt;
  logic             resp_valid;
  logic [WW-1:0]    resp_warp;
  logic [DW-1:0]    resp_data;
  logic             bram_wena;
  logic [AW-1:0]    bram_addra;
  logic [DW-1:0]    bram_dina;
  logic [DW-1:0]    bram_douta;

  icache_port_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .host_wr_en   (host_wr_en),
    .host_wr_addr (host_wr_addr),
    .host_wr_data (host_wr_data),
    .flush        (flush),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_gnt    (fetch_gnt),
    .resp_valid   (resp_valid),
    .resp_warp    (resp_warp),
    .resp_data    (resp_data),
    .bram_wena    (bram_wena),
    .bram_addra   (bram_addra),
    .bram_dina    (bram_dina),
    .bram_douta   (bram_douta)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // BRAM port A: registered address, registered read-first data
  logic [DW-1:0] mem [1<<AW];
  logic [AW-1:0] bram_addr_q;
  bit            preloaded = 1'b0;
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= init_word(i);
      preloaded <= 1'b1;
    end else begin
      if (bram_wena) mem[bram_addra] <= bram_dina;
      bram_addr_q <= bram_addra;
      bram_douta  <= mem[bram_addr_q];
    end
  end

  typedef struct {
    int                          due;
    int                          warp;
    logic [DW-1:0]               data;
  } exp_t;

  exp_t          q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = -1;
  int            m_ptr;
  int            m_due [NW];
  logic [DW-1:0] ref_mem [1<<AW];
  int            last_gi;
  logic [NW-1:0] seen_gnt;

  logic          s_rst_n;
  logic          s_wr;
  logic [AW-1:0] s_waddr;
  logic [DW-1:0] s_wdata;
  logic          s_flush;
  logic [NW-1:0] s_req;
  logic [AW-1:0] s_addr [NW];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    for (int w = 0; w < NW; w++) m_due[w] = -1;
    q.delete();
  endtask

  // one clock: apply stimulus, check port-A decision, advance the reference
  task automatic do_cycle();
    logic [NW-1:0] elig;
    int            gi;
    logic [AW-1:0] ea;
    @(posedge clk);
    #1;
    cyc++;
    rst_n        = s_rst_n;
    host_wr_en   = s_wr;
    host_wr_addr = s_waddr;
    host_wr_data = s_wdata;
    flush        = s_flush;
    fetch_req    = s_req;
    for (int w = 0; w < NW; w++) fetch_addr[w*AW +: AW] = s_addr[w];
    #2;
    gi   = -1;
    elig = '0;
    if (!s_rst_n) begin
      model_reset();
      chk("rst_gnt", 64'(fetch_gnt), 64'd0);
      chk("rst_wena", 64'(bram_wena), 64'd0);
      chk("rst_addra", 64'(bram_addra), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    end else begin
      for (int w = 0; w < NW; w++)
        elig[w] = s_req[w] && (m_due[w] < cyc || (m_due[w] == cyc && !s_flush));
      if (!s_wr) begin
        for (int k = 0; k < NW; k++) begin
          int w;
          w = (m_ptr + k) % NW;
          if (gi < 0 && elig[w]) gi = w;
        end
      end
      ea = s_wr ? s_waddr : ((gi >= 0) ? s_addr[gi] : '0);
      chk("gnt", 64'(fetch_gnt), (gi >= 0) ? (64'd1 << gi) : 64'd0);
      chk("wena", 64'(bram_wena), 64'(s_wr));
      chk("addra", 64'(bram_addra), 64'(ea));
      if (s_wr) chk("dina", 64'(bram_dina), 64'(s_wdata));
      if (s_flush) begin
        q.delete();
        for (int w = 0; w < NW; w++) m_due[w] = -1;
      end
      if (gi >= 0) begin
        m_ptr = (gi + 1) % NW;
        if (!s_flush) begin
          m_due[gi] = cyc + 2;
          q.push_back('{cyc + 2, gi, ref_mem[s_addr[gi]]});
        end
      end
      if (s_wr) ref_mem[s_waddr] = s_wdata;
    end
    last_gi  = gi;
    seen_gnt = fetch_gnt;
  endtask

  // response monitor: every resp_valid must match the head of the scoreboard
  always @(negedge clk) begin
    if (resp_valid) begin
      if (q.size() == 0 || q[0].due != cyc) begin
        chk("resp_unexpected", 64'(resp_warp), 64'hFFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_warp", 64'(resp_warp), 64'(e.warp));
        chk("resp_data", 64'(resp_data), 64'(e.data));
      end
    end else if (q.size() != 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      chk("resp_missing", 64'(resp_valid), 64'd1);
    end
  end

  task automatic idle(int n);
    s_req = '0;
    s_wr  = 1'b0;
    s_flush = 1'b0;
    repeat (n) do_cycle();
  endtask

  initial begin
    int gcount;
    rst_n = 1'b0; host_wr_en = 1'b0; host_wr_addr = '0; host_wr_data = '0;
    flush = 1'b0; fetch_req = '0; fetch_addr = '0;
    s_rst_n = 1'b0; s_wr = 1'b0; s_waddr = '0; s_wdata = '0; s_flush = 1'b0; s_req = '0;
    for (int w = 0; w < NW; w++) s_addr[w] = '0;
    for (int i = 0; i < (1<<AW); i++) ref_mem[i] = init_word(i);
    model_reset();
    last_gi = -1;
    repeat (3) do_cycle();

    // all warps request from the first cycle out of reset
    s_rst_n = 1'b1;
    s_req = '1;
    for (int w = 0; w < NW; w++) s_addr[w] = AW'(w * 4);
    for (int k = 0; k < 12; k++) begin
      do_cycle();
      if (k < NW) chk("order_0_to_7", 64'(seen_gnt), 64'd1 << k);
    end
    idle(4);

    // host write, then a fetch of the same address next cycle
    s_wr = 1'b1; s_waddr = AW'(5); s_wdata = 32'hDEAD_BEEF;
    s_req = 8'b0000_0110; s_addr[1] = AW'(5); s_addr[2] = AW'(9);
    do_cycle();
    chk("wr_blocks_gnt", 64'(seen_gnt), 64'd0);
    s_wr = 1'b0;
    repeat (6) do_cycle();
    idle(4);

    // two warps only: alternate with wrap-around
    s_req = 8'b0100_1000; s_addr[3] = AW'(33); s_addr[6] = AW'(66);
    repeat (12) do_cycle();
    idle(4);

    // two grants, then flush as the first response is due
    s_req = 8'b0000_0011; s_addr[0] = AW'(100); s_addr[1] = AW'(200);
    repeat (2) do_cycle();
    s_req = '0; s_flush = 1'b1;
    do_cycle();
    s_flush = 1'b0;
    repeat (3) do_cycle();
    s_req = 8'b0000_0011;
    repeat (6) do_cycle();
    idle(4);

    // long host write stream starves fetches until it ends
    s_req = '1;
    s_wr  = 1'b1;
    gcount = 0;
    for (int k = 0; k < 64; k++) begin
      s_waddr = AW'($urandom_range(0, 63));
      s_wdata = $urandom();
      do_cycle();
      if (seen_gnt != '0) gcount++;
    end
    chk("stream_grants", 64'(gcount), 64'd0);
    s_wr = 1'b0;
    do_cycle();
    chk("stream_first_gnt", 64'($countones(seen_gnt)), 64'd1);
    idle(4);

    // randomized traffic with a reset pulse in the middle
    for (int i = 0; i < 3000; i++) begin
      s_rst_n = !(i >= 1500 && i < 1503);
      for (int w = 0; w < NW; w++) begin
        if (s_req[w] && last_gi != w) begin
          if ($urandom_range(0, 15) == 0) s_req[w] = 1'b0;
        end else begin
          s_req[w]  = ($urandom_range(0, 2) != 0);
          s_addr[w] = AW'($urandom_range(0, 31));
        end
      end
      s_wr    = ($urandom_range(0, 5) == 0);
      s_waddr = AW'($urandom_range(0, 31));
      s_wdata = $urandom();
      s_flush = ($urandom_range(0, 30) == 0);
      do_cycle();
    end
    s_rst_n = 1'b1;
    idle(6);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
